// File: rtl/frame_loader_pkg.sv
// Shared definitions for the frame loader: FSM encoding and word geometry helpers.
package frame_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bytes packed into one RAM word.
    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    // Width of the byte-phase counter; at least one bit even for single-byte words.
    function automatic int phase_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/frame_loader_if.sv
// Byte-stream input and RAM write port of the frame loader, bundled as one interface.
interface frame_loader_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
);
    logic                     in_valid;
    logic [7:0]               in_data;
    logic                     in_ready;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;

    // Byte source / RAM side.
    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/frame_loader_byte_packer.sv
// Packs accepted bytes little-endian into RAM words; emits a one-cycle word_valid
// the cycle after the last byte of a word is accepted. The output word only changes
// on completion, so it holds between writes.
module byte_packer
    import frame_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_byte,
    input  logic                  valid,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid,
    output logic                  word_complete
);
    localparam int BYTES   = bytes_per_word(DATA_WIDTH);
    localparam int PHASE_W = phase_width(BYTES);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(BYTES - 1);

    logic [PHASE_W-1:0]    phase;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] merged;

    assign word_complete = valid && !clear && (phase == LAST_PHASE);

    // Current partial word with the incoming byte dropped into its lane.
    always_comb begin
        merged = acc;
        merged[8*phase +: 8] = in_byte;
    end

    // Byte phase, partial-word accumulator and the completed-word register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase      <= '0;
            acc        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= word_complete;
            if (clear) begin
                phase <= '0;
                acc   <= '0;
            end else if (valid) begin
                acc <= merged;
                if (word_complete) begin
                    phase <= '0;
                    word  <= merged;
                end else begin
                    phase <= phase + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/frame_loader.sv
// Frame loader: streams bytes into a frame RAM through byte_packer, owns the
// IDLE/LOAD/DONE control FSM and the write address / word counter.
module frame_loader
    import frame_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int DEPTH         = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    frame_loader_if.slave          bus,
    output logic                   busy,
    output logic                   done,
    output logic [ADDRESS_WIDTH:0] word_count
);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    state_t                   state;
    state_t                   state_next;
    logic                     start_go;
    logic                     last_write;
    logic                     in_ready;
    logic                     accept;
    logic                     word_complete;
    logic                     word_valid;
    logic [DATA_WIDTH-1:0]    word;
    logic [ADDRESS_WIDTH-1:0] wr_addr;

    // Start is only honoured outside LOAD, and abort always beats it.
    assign start_go   = start && !abort && (state != LOAD);
    // Write of the final frame word: ready drops here so nothing past the frame is taken.
    assign last_write = word_valid && (wr_addr == LAST_ADDR);
    assign in_ready   = (state == LOAD) && !abort && !last_write;
    assign accept     = bus.in_valid && in_ready;

    byte_packer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_byte      (bus.in_data),
        .valid        (accept),
        .clear        (abort || start_go),
        .word         (word),
        .word_valid   (word_valid),
        .word_complete(word_complete)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort has priority over every other transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_go)   state_next = LOAD;
            LOAD: if (abort)      state_next = IDLE;
                  else if (last_write) state_next = DONE;
            DONE: if (abort)      state_next = IDLE;
                  else if (start_go)   state_next = LOAD;
            default:              state_next = IDLE;
        endcase
    end

    // Write address and word counter: both advance as a word completes so they are
    // already valid during the wr_en cycle that follows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr    <= '0;
            word_count <= '0;
        end else if (start_go) begin
            wr_addr    <= '0;
            word_count <= '0;
        end else if (word_complete) begin
            wr_addr    <= word_count[ADDRESS_WIDTH-1:0];
            word_count <= word_count + 1'b1;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = word_valid;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = word;
    assign busy         = (state == LOAD);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader with a 4-word frame: directed streams push the
// expected RAM writes into a queue, and a monitor pops and compares on every wr_en.
module tb_frame_loader;
    import frame_loader_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW:0]   word_count;

    frame_loader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    frame_loader #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .word_count(word_count)
    );

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    wr_t exp_q[$];
    int  lat_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Offers count bytes starting at value first; must be called just after a rising edge.
    task automatic apply_stimulus(input logic [7:0] first, input int count, input bit gaps);
        for (int i = 0; i < count; i++) begin
            int  t;
            bit  taken;
            if (gaps) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(first + i);
            t     = 0;
            taken = 1'b0;
            while (!taken && t < 40) begin
                @(negedge clk);
                if (bus.in_ready) begin
                    taken = 1'b1;
                    if (i % 4 == 3) lat_q.push_back(cyc + 1);
                end
                tick();
                t++;
            end
            if (!taken) check_output("handshake_timeout", 64'd0, 64'd1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_output("wait_done", {63'd0, done}, 64'd1);
        tick();
    endtask

    task automatic push_frame();
        push_write(12'd0, 32'h03020100);
        push_write(12'd1, 32'h07060504);
        push_write(12'd2, 32'h0B0A0908);
        push_write(12'd3, 32'h0F0E0D0C);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Monitor: every RAM write must match the next expected address/data and latency.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_write", 64'd1, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_output("wr_addr", {52'd0, bus.wr_addr}, {52'd0, e.addr});
                check_output("wr_data", {32'd0, bus.wr_data}, {32'd0, e.data});
            end
            if (lat_q.size() == 0) begin
                check_output("write_latency_missing", 64'd1, 64'd0);
            end else begin
                int c;
                c = lat_q.pop_front();
                check_output("write_latency", 64'(cyc), 64'(c));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit accepted;
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;

        // Reset values.
        @(negedge clk);
        check_output("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check_output("rst_busy", {63'd0, busy}, 64'd0);
        check_output("rst_done", {63'd0, done}, 64'd0);
        check_output("rst_wr_data", {32'd0, bus.wr_data}, 64'd0);
        check_output("rst_word_count", {51'd0, word_count}, 64'd0);
        tick();

        // Full frame, in_valid held high; byte 0x10 must never be taken.
        $display("[TB] full frame, no gaps");
        push_frame();
        pulse_start();
        apply_stimulus(8'h00, 16, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h10;
        @(negedge clk);
        check_output("last_write_wr_en", {63'd0, bus.wr_en}, 64'd1);
        check_output("last_write_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check_output("last_write_done", {63'd0, done}, 64'd0);
        tick();
        @(negedge clk);
        check_output("frame_done", {63'd0, done}, 64'd1);
        check_output("frame_busy", {63'd0, busy}, 64'd0);
        check_output("frame_word_count", {51'd0, word_count}, 64'd4);
        accepted = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.in_ready && bus.in_valid) accepted = 1'b1;
        end
        check_output("byte_past_frame", {63'd0, accepted}, 64'd0);
        bus.in_valid = 1'b0;
        tick();

        // Restart from DONE, with random in_valid gaps.
        $display("[TB] restart from DONE, gapped stream");
        push_frame();
        pulse_start();
        @(negedge clk);
        check_output("restart_word_count", {51'd0, word_count}, 64'd0);
        check_output("restart_busy", {63'd0, busy}, 64'd1);
        tick();
        apply_stimulus(8'h00, 16, 1'b1);
        wait_done();

        // Abort after six bytes, then a clean frame.
        $display("[TB] abort mid-frame then reload");
        push_write(12'd0, 32'h03020100);
        pulse_start();
        apply_stimulus(8'h00, 6, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h06;
        abort        = 1'b1;
        @(negedge clk);
        check_output("abort_in_ready", {63'd0, bus.in_ready}, 64'd0);
        tick();
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_output("abort_busy", {63'd0, busy}, 64'd0);
        check_output("abort_done", {63'd0, done}, 64'd0);
        check_output("abort_word_count", {51'd0, word_count}, 64'd1);
        tick();
        push_frame();
        pulse_start();
        apply_stimulus(8'h00, 16, 1'b0);
        wait_done();
        check_output("reload_word_count", {51'd0, word_count}, 64'd4);

        // DONE -abort-> IDLE, then start and abort together from IDLE.
        $display("[TB] start and abort together");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_output("done_abort_done", {63'd0, done}, 64'd0);
        tick();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        check_output("start_abort_in_ready", {63'd0, bus.in_ready}, 64'd0);
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check_output("start_abort_busy", {63'd0, busy}, 64'd0);
        check_output("start_abort_ready_after", {63'd0, bus.in_ready}, 64'd0);
        tick();

        // Reset pulse mid-word: outputs return to reset values, no stray write.
        $display("[TB] reset mid-word");
        push_write(12'd0, 32'h03020100);
        pulse_start();
        apply_stimulus(8'h00, 6, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h06;
        rst_n        = 1'b0;
        tick();
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_output("mid_rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
        check_output("mid_rst_busy", {63'd0, busy}, 64'd0);
        check_output("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check_output("mid_rst_wr_addr", {52'd0, bus.wr_addr}, 64'd0);
        check_output("mid_rst_wr_data", {32'd0, bus.wr_data}, 64'd0);
        check_output("mid_rst_word_count", {51'd0, word_count}, 64'd0);
        repeat (5) tick();

        check_output("writes_outstanding", 64'(exp_q.size()), 64'd0);
        check_output("latencies_outstanding", 64'(lat_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32: RAM word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDRESS_WIDTH, default 12: RAM address width.
REQ-003 Parameter DEPTH, default 4096: words per frame; SHALL satisfy 1 <= DEPTH <= 2**ADDRESS_WIDTH.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins a frame load at address 0.
REQ-007 abort  input  1  one-cycle pulse; cancels the load in progress.
REQ-008 in_valid  input  1  byte-stream valid.
REQ-009 in_data  input  8  byte-stream data.
REQ-010 in_ready  output  1  byte-stream ready; a byte transfers when in_valid && in_ready at a rising edge.
REQ-011 wr_en  output  1  RAM write strobe, one cycle per word.
REQ-012 wr_addr  output  ADDRESS_WIDTH  RAM write address.
REQ-013 wr_data  output  DATA_WIDTH  RAM write data.
REQ-014 busy  output  1  high while in LOAD.
REQ-015 done  output  1  high in DONE: full frame written.
REQ-016 word_count  output  ADDRESS_WIDTH+1  words written since last start.

Function
REQ-017 States SHALL be IDLE, LOAD, DONE. Transitions: IDLE -start-> LOAD; LOAD -last word written-> DONE; LOAD -abort-> IDLE; DONE -start-> LOAD; DONE -abort-> IDLE.
REQ-018 in_ready SHALL be 1 only in LOAD. Bytes offered in IDLE or DONE SHALL NOT be consumed.
REQ-019 Bytes SHALL pack little-endian: the first accepted byte of a word goes to wr_data[7:0], byte k to bits [8k+7:8k]. BYTES = DATA_WIDTH/8.
REQ-020 On acceptance of byte BYTES-1 of a word, the next cycle SHALL have wr_en=1, wr_data=the packed word, and wr_addr=word index. Latency is exactly one cycle.
REQ-021 wr_en SHALL be 0 on all other cycles. wr_addr and wr_data SHALL hold their values while wr_en=0.
REQ-022 The word index SHALL start at 0 on start and increment by 1 after each write. It SHALL never exceed DEPTH-1, with no wrap within a frame.
REQ-023 word_count SHALL increment on the same cycle that wr_en is asserted.
REQ-024 On the write of word DEPTH-1, the next state SHALL be DONE. in_ready SHALL drop in that same write cycle so that no byte beyond the frame is accepted.
REQ-025 start during LOAD SHALL be ignored.
REQ-026 start in DONE SHALL clear word_count, the byte phase and the address, then enter LOAD.
REQ-027 abort in LOAD SHALL discard any partial word and go to IDLE; a write already issued SHALL complete.
REQ-028 start and abort in the same cycle: abort SHALL win.
REQ-029 A byte presented in the cycle abort is asserted SHALL NOT be consumed. in_ready SHALL be 0 in that cycle.
REQ-030 in_valid gaps SHALL stall packing without losing the byte phase.

Reset
REQ-031 With rst_n=0 at a rising edge, the block SHALL reset as follows:
- state = IDLE
- in_ready = 0, wr_en = 0, busy = 0, done = 0
- wr_addr = 0, wr_data = 0, word_count = 0
- byte phase = 0
REQ-032 Reset SHALL dominate start and abort. Reset mid-LOAD SHALL discard partial data and issue no write.

Structure
REQ-033 The state encoding (IDLE, LOAD, DONE) and the BYTES derivation SHALL live in the shared project package.
REQ-034 Byte packing SHALL be a sub-module byte_packer:
- inputs: byte, valid, clear
- outputs: word, word_valid
- frame_loader owns the FSM and address counter.
REQ-035 wr_* SHALL connect directly to the write port of the dual-port frame RAM, whose read port feeds the display path.

Verification
REQ-036 DEPTH=4, reset, start, stream bytes 00..0F with in_valid held high:
- writes (addr 0..3) = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C;
- done=1 one cycle after the last write;
- byte 0x10 is offered but never accepted.
REQ-037 Random in_valid gaps, same bytes: identical write sequence; each wr_en occurs exactly 1 cycle after the last-byte handshake.
REQ-038 abort after 6 bytes, then start and stream 16 bytes:
- first pass: one write of 0x03020100 at addr 0, then return to IDLE;
- second pass: restart at addr 0; word_count ends at 4.
REQ-039 start and abort in the same cycle from IDLE: state stays IDLE, in_ready=0.
REQ-040 rst_n low for 1 cycle mid-word in LOAD: all outputs at reset values next cycle; no wr_en pulse.
REQ-041 start in DONE: word_count=0, busy=1, and the next frame's writes begin at addr 0.
